// File: rtl/input_conditioner_if.sv
// Pin-side bundle of the input conditioner: raw active-low buttons and switches in,
// debounced levels, press pulses and synchronized/snapshotted switches out.
interface input_conditioner_if #(
    parameter int SW_WIDTH = 8
);
    logic                ClearALoadB_n;
    logic                Execute_n;
    logic [SW_WIDTH-1:0] Switches;
    logic                ClearALoadB_H;
    logic                ClearALoadB_P;
    logic                Execute_H;
    logic                Execute_P;
    logic [SW_WIDTH-1:0] Switches_S;
    logic [SW_WIDTH-1:0] Switches_L;

    modport master (
        output ClearALoadB_n, Execute_n, Switches,
        input  ClearALoadB_H, ClearALoadB_P, Execute_H, Execute_P, Switches_S, Switches_L
    );

    modport slave (
        input  ClearALoadB_n, Execute_n, Switches,
        output ClearALoadB_H, ClearALoadB_P, Execute_H, Execute_P, Switches_S, Switches_L
    );
endinterface

// File: rtl/input_conditioner.sv
// Synchronizes and debounces the two pushbuttons into levels and press pulses, and
// synchronizes the data switches with a snapshot taken on each ClearA/LoadB press.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SW_WIDTH        = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input_conditioner_if.slave pins
);
    localparam int                 CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel 0 is ClearA/LoadB, channel 1 is Execute.
    logic [1:0]          raw;
    logic [1:0]          sync1;
    logic [1:0]          sync2;
    logic [1:0]          deb;
    logic [1:0]          deb_d;
    logic [1:0]          deb_nxt;
    logic [CNT_W-1:0]    cnt     [2];
    logic [CNT_W-1:0]    cnt_nxt [2];
    logic [SW_WIDTH-1:0] sw_sync1;
    logic [SW_WIDTH-1:0] sw_sync2;
    logic [SW_WIDTH-1:0] sw_snap;

    assign raw = {pins.Execute_n, pins.ClearALoadB_n};

    // Any mismatch run shorter than DEBOUNCE_CYCLES clears the count and leaves deb alone.
    always_comb begin
        deb_nxt = deb;
        for (int i = 0; i < 2; i++) begin
            cnt_nxt[i] = '0;
            if (~sync2[i] != deb[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    deb_nxt[i] = ~deb[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync1    <= '1;
            sync2    <= '1;
            deb      <= '0;
            deb_d    <= '0;
            cnt[0]   <= '0;
            cnt[1]   <= '0;
            sw_sync1 <= '0;
            sw_sync2 <= '0;
            sw_snap  <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            deb      <= deb_nxt;
            deb_d    <= deb;
            cnt[0]   <= cnt_nxt[0];
            cnt[1]   <= cnt_nxt[1];
            sw_sync1 <= pins.Switches;
            sw_sync2 <= sw_sync1;
            // Snapshot lands on the same edge deb rises, so it is valid during the pulse.
            if (deb_nxt[0] && !deb[0]) begin
                sw_snap <= sw_sync2;
            end
        end
    end

    assign pins.ClearALoadB_H = deb[0];
    assign pins.ClearALoadB_P = deb[0] & ~deb_d[0];
    assign pins.Execute_H     = deb[1];
    assign pins.Execute_P     = deb[1] & ~deb_d[1];
    assign pins.Switches_S    = sw_sync2;
    assign pins.Switches_L    = sw_snap;
endmodule
